fetch_stage: RTL and testbench

- Instruction-fetch stage of the 19-bit pipelined core; sits directly upstream of the decode controller.
- Owns the PC register, the next-PC mux and adder, an 8-entry return-address stack, and the IF/ID pipeline register.
- The IF/ID register drives the controller's allBits input. The controller's stall, push, pop, pcInputSel and pcAdderInputASel outputs are consumed here.

---
 rtl/fetch_stage.sv | 141 ++++++++++++++
 tb/tb_fetch_stage.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, 8-entry
// return-address stack and the IF/ID pipeline register feeding decode.
module fetch_stage #(
  parameter int                 ADDR_W      = 12,
  parameter int                 INSTR_W     = 19,
  parameter int                 STACK_DEPTH = 8,
  parameter logic [INSTR_W-1:0] NOP_INSTR   = 19'h7FFFF
) (
  input  logic               clock,
  input  logic               init_signal,
  output logic [ADDR_W-1:0]  inst_addr,
  input  logic [INSTR_W-1:0] inst_data,
  input  logic               hold,
  input  logic               stall,
  input  logic [1:0]         pcInputSel,
  input  logic               pcAdderInputASel,
  input  logic               push,
  input  logic               pop,
  output logic [INSTR_W-1:0] allBits,
  output logic [ADDR_W-1:0]  id_pc,
  output logic               id_valid,
  output logic [3:0]         stack_depth,
  output logic               stack_overflow,
  output logic               stack_underflow
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam logic [3:0] DEPTH = 4'(STACK_DEPTH);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  idpc_q, idpc_d;
  logic               vld_q, vld_d;
  logic [3:0]         sp_q, sp_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];

  logic [IDX_W-1:0]   top_idx;
  logic [IDX_W-1:0]   stk_widx;
  logic               stk_we;
  logic [ADDR_W-1:0]  ret_tgt;
  logic [ADDR_W-1:0]  br_off;
  logic [ADDR_W-1:0]  link_addr;

  assign top_idx   = IDX_W'(sp_q - 4'd1);
  assign ret_tgt   = (sp_q != 4'd0) ? stack_q[top_idx] : '0;
  assign br_off    = {{(ADDR_W-8){ir_q[7]}}, ir_q[7:0]};
  assign link_addr = idpc_q + ADDR_W'(1);

  // Next-state for PC, IF/ID register, stack pointer and sticky flags
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    idpc_d   = idpc_q;
    vld_d    = vld_q;
    sp_d     = sp_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    stk_we   = 1'b0;
    stk_widx = sp_q[IDX_W-1:0];

    // pop wins over push for the target: a simultaneous push/pop returns
    if (pop) begin
      pc_d = ret_tgt;
    end else if (push) begin
      pc_d = ir_q[ADDR_W-1:0];
    end else begin
      unique case (pcInputSel)
        2'b01:   pc_d = ir_q[ADDR_W-1:0];
        2'b10:   pc_d = ret_tgt;
        2'b00:   pc_d = pcAdderInputASel ? pc_q + ADDR_W'(1) : idpc_q + br_off;
        default: pc_d = pc_q;
      endcase
    end

    if (push && !pop) begin
      if (sp_q < DEPTH) begin
        stk_we = 1'b1;
        sp_d   = sp_q + 4'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (pop) begin
      if (sp_q == 4'd0) begin
        udf_d = 1'b1;
      end else if (push) begin
        // illegal push+pop: replace top entry in place
        stk_we   = 1'b1;
        stk_widx = top_idx;
      end else begin
        sp_d = sp_q - 4'd1;
      end
    end

    if (stall) begin
      ir_d  = NOP_INSTR;
      vld_d = 1'b0;
    end else begin
      ir_d   = inst_data;
      idpc_d = pc_q;
      vld_d  = 1'b1;
    end
  end

  // Stage registers: reset first, hold freezes everything
  always_ff @(posedge clock) begin
    if (init_signal) begin
      pc_q   <= '0;
      ir_q   <= NOP_INSTR;
      idpc_q <= '0;
      vld_q  <= 1'b0;
      sp_q   <= 4'd0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else if (!hold) begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      idpc_q <= idpc_d;
      vld_q  <= vld_d;
      sp_q   <= sp_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  // Return-address storage; contents need no reset
  always_ff @(posedge clock) begin
    if (!init_signal && !hold && stk_we)
      stack_q[stk_widx] <= link_addr;
  end

  assign inst_addr       = pc_q;
  assign allBits         = ir_q;
  assign id_pc           = idpc_q;
  assign id_valid        = vld_q;
  assign stack_depth     = sp_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = udf_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: each step queues its hand-computed
// post-edge state; a negedge monitor pops and compares.
module tb_fetch_stage;

  localparam logic [18:0] NOP = 19'h7FFFF;

  logic        clock = 1'b0;
  logic        init_signal, hold, stall, pcAdderInputASel, push, pop;
  logic [1:0]  pcInputSel;
  logic [11:0] inst_addr, id_pc;
  logic [18:0] inst_data, allBits;
  logic        id_valid, stack_overflow, stack_underflow;
  logic [3:0]  stack_depth;

  logic [18:0] mem [4096];
  assign inst_data = mem[inst_addr];

  always #5 clock = ~clock;

  fetch_stage dut (
    .clock(clock), .init_signal(init_signal), .inst_addr(inst_addr),
    .inst_data(inst_data), .hold(hold), .stall(stall),
    .pcInputSel(pcInputSel), .pcAdderInputASel(pcAdderInputASel),
    .push(push), .pop(pop), .allBits(allBits), .id_pc(id_pc),
    .id_valid(id_valid), .stack_depth(stack_depth),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  typedef struct packed {
    logic [11:0] pc;
    logic [18:0] ab;
    logic [11:0] idpc;
    logic        v;
    logic [3:0]  d;
    logic        o;
    logic        u;
  } exp_t;

  exp_t  exp_q [$];
  string nm_q  [$];
  int    tests = 0;
  int    fails = 0;

  exp_t  mon_e, mon_g;
  string mon_nm;

  // Monitor: compare one queued expectation per cycle, away from the edge
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = nm_q.pop_front();
      mon_g  = '{inst_addr, allBits, id_pc, id_valid, stack_depth,
                 stack_overflow, stack_underflow};
      tests++;
      if (mon_g !== mon_e) begin
        fails++;
        $display("FAIL %s: got pc=%h ab=%h idpc=%h v=%b d=%0d o=%b u=%b, expected pc=%h ab=%h idpc=%h v=%b d=%0d o=%b u=%b",
                 mon_nm, mon_g.pc, mon_g.ab, mon_g.idpc, mon_g.v, mon_g.d, mon_g.o, mon_g.u,
                 mon_e.pc, mon_e.ab, mon_e.idpc, mon_e.v, mon_e.d, mon_e.o, mon_e.u);
      end
    end
  end

  task automatic step(input string nm, input logic i_init, i_hold, i_stall,
                      input logic [1:0] i_sel, input logic i_asel, i_push, i_pop,
                      input logic [11:0] e_pc, input logic [18:0] e_ab,
                      input logic [11:0] e_idpc, input logic e_v,
                      input logic [3:0] e_d, input logic e_o, e_u);
    exp_t e;
    init_signal = i_init; hold = i_hold; stall = i_stall; pcInputSel = i_sel;
    pcAdderInputASel = i_asel; push = i_push; pop = i_pop;
    @(posedge clock);
    e = '{e_pc, e_ab, e_idpc, e_v, e_d, e_o, e_u};
    exp_q.push_back(e);
    nm_q.push_back(nm);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 19'(i);
    mem[12'h003] = 19'h70020;
    mem[12'h004] = 19'h700A5;
    mem[12'h0A6] = 19'h70010;
    mem[12'h010] = 19'h000FC;
    mem[12'h00D] = 19'h70FFE;
    mem[12'hFFE] = 19'h00005;
    mem[12'h020] = 19'h70100;

    //    name          init hold stl sel   as psh pop  pc       ab         idpc     v  d  o  u
    step("reset0",      1, 0, 0, 2'b00, 1, 0, 0, 12'h000, NOP,       12'h000, 0, 0, 0, 0);
    step("reset1",      1, 0, 0, 2'b00, 1, 0, 0, 12'h000, NOP,       12'h000, 0, 0, 0, 0);
    step("seq1",        0, 0, 0, 2'b00, 1, 0, 0, 12'h001, 19'h00000, 12'h000, 1, 0, 0, 0);
    step("seq2",        0, 0, 0, 2'b00, 1, 0, 0, 12'h002, 19'h00001, 12'h001, 1, 0, 0, 0);
    step("seq3",        0, 0, 0, 2'b00, 1, 0, 0, 12'h003, 19'h00002, 12'h002, 1, 0, 0, 0);
    step("seq4",        0, 0, 0, 2'b00, 1, 0, 0, 12'h004, 19'h70020, 12'h003, 1, 0, 0, 0);
    step("seq5",        0, 0, 0, 2'b00, 1, 0, 0, 12'h005, 19'h700A5, 12'h004, 1, 0, 0, 0);
    step("jump_a5",     0, 0, 1, 2'b01, 1, 0, 0, 12'h0A5, NOP,       12'h004, 0, 0, 0, 0);
    step("after_jump",  0, 0, 0, 2'b00, 1, 0, 0, 12'h0A6, 19'h000A5, 12'h0A5, 1, 0, 0, 0);
    step("seq_a7",      0, 0, 0, 2'b00, 1, 0, 0, 12'h0A7, 19'h70010, 12'h0A6, 1, 0, 0, 0);
    step("jump_010",    0, 0, 1, 2'b01, 1, 0, 0, 12'h010, NOP,       12'h0A6, 0, 0, 0, 0);
    step("seq_011",     0, 0, 0, 2'b00, 1, 0, 0, 12'h011, 19'h000FC, 12'h010, 1, 0, 0, 0);
    step("br_back",     0, 0, 1, 2'b00, 0, 0, 0, 12'h00C, NOP,       12'h010, 0, 0, 0, 0);
    step("seq_00d",     0, 0, 0, 2'b00, 1, 0, 0, 12'h00D, 19'h0000C, 12'h00C, 1, 0, 0, 0);
    step("seq_00e",     0, 0, 0, 2'b00, 1, 0, 0, 12'h00E, 19'h70FFE, 12'h00D, 1, 0, 0, 0);
    step("jump_ffe",    0, 0, 1, 2'b01, 1, 0, 0, 12'hFFE, NOP,       12'h00D, 0, 0, 0, 0);
    step("seq_fff",     0, 0, 0, 2'b00, 1, 0, 0, 12'hFFF, 19'h00005, 12'hFFE, 1, 0, 0, 0);
    step("br_wrap",     0, 0, 1, 2'b00, 0, 0, 0, 12'h003, NOP,       12'hFFE, 0, 0, 0, 0);
    step("seq_004",     0, 0, 0, 2'b00, 1, 0, 0, 12'h004, 19'h70020, 12'h003, 1, 0, 0, 0);
    step("jump_020",    0, 0, 1, 2'b01, 1, 0, 0, 12'h020, NOP,       12'h003, 0, 0, 0, 0);
    step("seq_021",     0, 0, 0, 2'b00, 1, 0, 0, 12'h021, 19'h70100, 12'h020, 1, 0, 0, 0);
    step("call_100",    0, 0, 1, 2'b00, 1, 1, 0, 12'h100, NOP,       12'h020, 0, 1, 0, 0);
    step("seq_101",     0, 0, 0, 2'b00, 1, 0, 0, 12'h101, 19'h00100, 12'h100, 1, 1, 0, 0);
    step("return",      0, 0, 1, 2'b10, 1, 0, 1, 12'h021, NOP,       12'h100, 0, 0, 0, 0);
    step("seq_022",     0, 0, 0, 2'b00, 1, 0, 0, 12'h022, 19'h00021, 12'h021, 1, 0, 0, 0);
    step("push1",       0, 0, 1, 2'b00, 1, 1, 0, 12'h021, NOP,       12'h021, 0, 1, 0, 0);
    step("push2",       0, 0, 1, 2'b00, 1, 1, 0, 12'hFFF, NOP,       12'h021, 0, 2, 0, 0);
    for (int k = 3; k <= 8; k++)
      step("push_n",    0, 0, 1, 2'b00, 1, 1, 0, 12'hFFF, NOP,       12'h021, 0, 4'(k), 0, 0);
    step("push9_ovf",   0, 0, 1, 2'b00, 1, 1, 0, 12'hFFF, NOP,       12'h021, 0, 8, 1, 0);
    step("pc_wrap",     0, 0, 1, 2'b00, 1, 0, 0, 12'h000, NOP,       12'h021, 0, 8, 1, 0);
    for (int k = 0; k < 8; k++)
      step("pop_n",     0, 0, 1, 2'b00, 1, 0, 1, 12'h022, NOP,       12'h021, 0, 4'(7 - k), 1, 0);
    step("pop_empty",   0, 0, 1, 2'b00, 1, 0, 1, 12'h000, NOP,       12'h021, 0, 0, 1, 1);
    step("flags_stick", 0, 0, 0, 2'b00, 1, 0, 0, 12'h001, 19'h00000, 12'h000, 1, 0, 1, 1);
    step("push_nostl",  0, 0, 0, 2'b00, 1, 1, 0, 12'h000, 19'h00001, 12'h001, 1, 1, 1, 1);
    for (int k = 0; k < 3; k++)
      step("hold",      0, 1, 1, 2'b01, 1, 1, 0, 12'h000, 19'h00001, 12'h001, 1, 1, 1, 1);
    step("unhold",      0, 0, 0, 2'b00, 1, 0, 0, 12'h001, 19'h00000, 12'h000, 1, 1, 1, 1);
    step("push_pop",    0, 0, 1, 2'b00, 1, 1, 1, 12'h001, NOP,       12'h000, 0, 1, 1, 1);
    step("init_call",   1, 0, 1, 2'b00, 1, 1, 0, 12'h000, NOP,       12'h000, 0, 0, 0, 0);
    step("post_init",   0, 0, 0, 2'b00, 1, 0, 0, 12'h001, 19'h00000, 12'h000, 1, 0, 0, 0);
    step("sel_rsvd",    0, 0, 0, 2'b11, 1, 0, 0, 12'h001, 19'h00001, 12'h001, 1, 0, 0, 0);

    init_signal = 1'b0; hold = 1'b1; stall = 1'b0; push = 1'b0; pop = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
